// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared constants and types for the register scoreboard
package sb_pkg;
  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;
  localparam int STALL_W  = 8;
  localparam int CNT_W    = 6;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_W-1:0]    reg_idx_t;
  typedef logic [NUM_REGS-1:0] reg_vec_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue, writeback, flush and status bundle for the scoreboard
interface reg_scoreboard_if;
  import sb_pkg::*;

  logic                 iss_valid;
  reg_idx_t             iss_rs;
  reg_idx_t             iss_rt;
  reg_idx_t             iss_rd;
  logic                 iss_rd_we;
  logic                 iss_ready;
  logic                 wb0_valid;
  reg_idx_t             wb0_rd;
  logic                 wb1_valid;
  reg_idx_t             wb1_rd;
  logic                 flush;
  reg_vec_t             busy;
  logic [CNT_W-1:0]     outstanding;
  logic [STALL_W-1:0]   stall_cnt;
  logic                 wb_err;

  modport master (
    output iss_valid, iss_rs, iss_rt, iss_rd, iss_rd_we,
    output wb0_valid, wb0_rd, wb1_valid, wb1_rd, flush,
    input  iss_ready, busy, outstanding, stall_cnt, wb_err
  );

  modport slave (
    input  iss_valid, iss_rs, iss_rt, iss_rd, iss_rd_we,
    input  wb0_valid, wb0_rd, wb1_valid, wb1_rd, flush,
    output iss_ready, busy, outstanding, stall_cnt, wb_err
  );
endinterface

// File: rtl/one_hot_decoder.sv
// rtl/one_hot_decoder.sv - gated 5-to-32 one-hot decoder
module one_hot_decoder
  import sb_pkg::*;
(
  input  logic     en,
  input  reg_idx_t idx,
  output reg_vec_t onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - busy-bit scoreboard gating issue on RAW/WAW hazards
module reg_scoreboard
  import sb_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  reg_scoreboard_if.slave sb
);
  reg_vec_t             busy_q;
  logic [CNT_W-1:0]     outstanding_q;
  logic [STALL_W-1:0]   stall_q;
  logic                 err_q;

  reg_vec_t             set_vec;
  reg_vec_t             clr0_vec;
  reg_vec_t             clr1_vec;
  reg_vec_t             clr_vec;
  reg_vec_t             eff_busy;
  reg_vec_t             busy_nxt;
  logic                 hazard;
  logic                 ready;
  logic                 fire;
  logic                 wb0_bad;
  logic                 wb1_bad;

  function automatic logic [CNT_W-1:0] popcount(input reg_vec_t v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) c = c + {{(CNT_W-1){1'b0}}, v[i]};
    return c;
  endfunction

  one_hot_decoder u_dec_set (.en(fire),         .idx(sb.iss_rd), .onehot(set_vec));
  one_hot_decoder u_dec_wb0 (.en(sb.wb0_valid), .idx(sb.wb0_rd), .onehot(clr0_vec));
  one_hot_decoder u_dec_wb1 (.en(sb.wb1_valid), .idx(sb.wb1_rd), .onehot(clr1_vec));

  // Same-cycle writebacks are forwarded by the datapath, so they resolve hazards now.
  assign clr_vec  = clr0_vec | clr1_vec;
  assign eff_busy = busy_q & ~clr_vec;

  assign hazard = eff_busy[sb.iss_rs] | eff_busy[sb.iss_rt] |
                  (sb.iss_rd_we & eff_busy[sb.iss_rd]);
  assign ready  = ~reset & ~sb.flush & ~hazard;
  assign fire   = sb.iss_valid & ready & sb.iss_rd_we & (sb.iss_rd != ZERO_REG);

  always_comb begin
    busy_nxt    = sb.flush ? '0 : (eff_busy | set_vec);
    busy_nxt[0] = 1'b0;
  end

  assign wb0_bad = sb.wb0_valid & (sb.wb0_rd != ZERO_REG) & ~busy_q[sb.wb0_rd];
  assign wb1_bad = sb.wb1_valid & (sb.wb1_rd != ZERO_REG) & ~busy_q[sb.wb1_rd];

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      stall_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      busy_q        <= busy_nxt;
      outstanding_q <= popcount(busy_nxt);
      if (sb.iss_valid && !ready && (stall_q != {STALL_W{1'b1}}))
        stall_q <= stall_q + 1'b1;
      if (!sb.flush && (wb0_bad || wb1_bad))
        err_q <= 1'b1;
    end
  end

  assign sb.iss_ready   = ready;
  assign sb.busy        = busy_q;
  assign sb.outstanding = outstanding_q;
  assign sb.stall_cnt   = stall_q;
  assign sb.wb_err      = err_q;
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register scoreboard for the out-of-order core: tracks which of the 32 architectural registers have a write in flight and gates instruction issue on RAW and WAW hazards. It sits between decode/issue and the two writeback paths: the ALU path and the multdiv path. Each cycle it sets busy bits for newly issued destinations, clears them on writeback, and clears all of them on a pipeline flush. It also keeps an outstanding-write count, a saturating stall counter and a sticky error flag for debug.

## Interface
- NUM_REGS, 32, register count; fixed by the 5-bit register specifier.
- REG_W, 5, register specifier width.
- STALL_W, 8, stall counter width.
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the clock edge.
- iss_valid  in  1  issue stage presents an instruction.
- iss_rs, iss_rt  in  5 each  source register specifiers.
- iss_rd  in  5  destination register specifier.
- iss_rd_we  in  1  instruction writes iss_rd.
- iss_ready  out  1  issue permitted this cycle.
- wb0_valid, wb0_rd  in  1, 5  ALU writeback completes for wb0_rd.
- wb1_valid, wb1_rd  in  1, 5  multdiv writeback completes for wb1_rd.
- flush  in  1  squash all in-flight writes.
- busy  out  32  registered busy vector; bit i means register i has a pending write.
- outstanding  out  6  registered popcount of busy.
- stall_cnt  out  8  saturating count of stalled issue cycles.
- wb_err  out  1  sticky flag: writeback seen for a register that was not busy.

## Operation
- clr = decode(wb0_rd) gated by wb0_valid, ORed with decode(wb1_rd) gated by wb1_valid.
- eff_busy = busy & ~clr. A writeback in the same cycle counts as resolved; the datapath forwards that value.
- hazard = eff_busy[iss_rs] | eff_busy[iss_rt] | (iss_rd_we & eff_busy[iss_rd]).
- iss_ready = !reset & !flush & !hazard. iss_ready does not depend on iss_valid.
- Register 0 is never busy. Bit 0 is forced to 0 on every update, and specifier 0 never causes a hazard.
- fire = iss_valid & iss_ready & iss_rd_we & (iss_rd != 0); set = decode(iss_rd) gated by fire.
- Next busy is (busy & ~clr) | set, with bit 0 forced to 0.
- If set and clr hit the same register in one cycle, set wins and the register stays busy with the new write.
- If wb0 and wb1 hit the same register, the bit is cleared once and no error is raised.
- On flush, next busy is 0 and all writebacks in that cycle are ignored.
- wb_err sets when a valid writeback targets a register other than 0 whose current busy bit is 0, and flush is low. It clears only on reset.
- stall_cnt increments when iss_valid & !iss_ready, including stalls caused by flush. It saturates at 255 and clears only on reset.
- outstanding is the popcount of the next busy value, registered alongside busy.

## Timing
- All outputs reset to 0: busy = 0, outstanding = 0, stall_cnt = 0, wb_err = 0, iss_ready = 0 while reset is high.
- iss_ready is combinational from current busy, the wb inputs and flush, with zero-cycle latency. The issue handshake completes in the cycle iss_valid & iss_ready is true.
- busy and outstanding reflect an issue or writeback one cycle after it occurs.
- A reset asserted mid-operation discards all pending state on that edge; a writeback in the following cycle raises wb_err.
- A flush takes effect on the next edge. In the cycle after a flush, issue proceeds with an all-clear scoreboard.

## Structure
- Shared package sb_pkg holds NUM_REGS, REG_W and ZERO_REG = 5'd0.
- Sub-module: three instances of the existing one_hot_decoder (5-to-32) for set, wb0 clear and wb1 clear. Source lookups index the busy vector directly.
- The popcount is a local combinational function inside reg_scoreboard; there is no separate module.

## Test plan
- Reset, then issue rd=5 with we=1 → iss_ready = 1; next cycle busy[5] = 1 and outstanding = 1.
- With r5 busy, issue rs=5 → iss_ready = 0 and stall_cnt increments by one per cycle. Then wb0 rd=5 in the same cycle → iss_ready = 1 that cycle and busy[5] = 0 next cycle.
- Issue rd=7 in the same cycle as wb1 rd=7 (r7 busy) → busy[7] stays 1 and outstanding is unchanged.
- wb0 and wb1 both rd=3 with r3 busy → busy[3] = 0 and wb_err = 0. Then wb0 rd=9 with r9 idle → wb_err = 1 and stays 1.
- Make r1, r2 and r4 busy, then assert flush with iss_valid=1 → iss_ready = 0; next cycle busy = 0 and outstanding = 0.
- Issue rd=0 with we=1 → busy stays 0. Hold a hazard for 300 cycles → stall_cnt = 255.
